// File: rtl/booth_seq_mult.sv
// Sequential radix-2 Booth multiplier: FSM, step counter and shift/add datapath in one block.
// Optional macro BOOTH_UNSIGNED_EN adds the unsigned_mode port (zero-extended operands, one extra step).
module booth_seq_mult #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 abort,
`ifdef BOOTH_UNSIGNED_EN
    input  logic                 unsigned_mode,
`endif
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic [2*WIDTH-1:0]   product,
    output logic                 ready,
    output logic                 busy
);

`ifdef BOOTH_UNSIGNED_EN
    localparam int QW       = WIDTH + 1;
    localparam int MAX_ITER = WIDTH + 1;
`else
    localparam int QW       = WIDTH;
    localparam int MAX_ITER = WIDTH;
`endif
    localparam int CW = $clog2(MAX_ITER + 1);

    typedef enum logic [1:0] {IDLE, SETUP, PROCESS, READY} state_t;

    state_t               state, state_next;
    logic [WIDTH:0]       acc, m_reg, m_ext, acc_sum, acc_sh;
    logic [QW-1:0]        q_reg, q_ext, q_sh;
    logic                 q_m1;
    logic [CW-1:0]        count, iter_last;
    logic                 last_step, accept;
    logic [2*WIDTH-1:0]   product_next;

    assign accept    = (state == IDLE) && start && !abort;
    assign last_step = (count == iter_last);

`ifdef BOOTH_UNSIGNED_EN
    logic mode_uns;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            mode_uns <= 1'b0;
        else if (accept)
            mode_uns <= unsigned_mode;
    end

    assign m_ext     = unsigned_mode ? {1'b0, multiplicand} : {multiplicand[WIDTH-1], multiplicand};
    assign q_ext     = unsigned_mode ? {1'b0, multiplier}   : {multiplier[WIDTH-1], multiplier};
    assign iter_last = mode_uns ? CW'(WIDTH) : CW'(WIDTH - 1);
    // Signed mode stops one step early, so the unconsumed sign bit still sits in q_sh[0].
    assign product_next = mode_uns ? {acc_sh[WIDTH-2:0], q_sh}
                                   : {acc_sh[WIDTH-1:0], q_sh[QW-1:1]};
`else
    assign m_ext        = {multiplicand[WIDTH-1], multiplicand};
    assign q_ext        = multiplier;
    assign iter_last    = CW'(WIDTH - 1);
    assign product_next = {acc_sh[WIDTH-1:0], q_sh};
`endif

    // Booth add/subtract followed by arithmetic right shift of {A,Q,Q-1}.
    always_comb begin
        acc_sum = acc;
        case ({q_reg[0], q_m1})
            2'b01:   acc_sum = acc + m_reg;
            2'b10:   acc_sum = acc - m_reg;
            default: acc_sum = acc;
        endcase
        acc_sh = {acc_sum[WIDTH], acc_sum[WIDTH:1]};
        q_sh   = {acc_sum[0], q_reg[QW-1:1]};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        ready      = 1'b0;
        busy       = 1'b1;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (accept)
                    state_next = SETUP;
            end
            SETUP: begin
                state_next = abort ? IDLE : PROCESS;
            end
            PROCESS: begin
                if (abort)
                    state_next = IDLE;
                else if (last_step)
                    state_next = READY;
            end
            READY: begin
                ready      = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // An abort suppresses the step, so product keeps its previous value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            m_reg   <= '0;
            q_reg   <= '0;
            q_m1    <= 1'b0;
            acc     <= '0;
            count   <= '0;
            product <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        m_reg <= m_ext;
                        q_reg <= q_ext;
                    end
                end
                SETUP: begin
                    acc   <= '0;
                    q_m1  <= 1'b0;
                    count <= '0;
                end
                PROCESS: begin
                    if (!abort) begin
                        acc   <= acc_sh;
                        q_reg <= q_sh;
                        q_m1  <= q_reg[0];
                        count <= count + 1'b1;
                        if (last_step)
                            product <= product_next;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_booth_seq_mult.sv
// Randomized and directed self-checking bench for booth_seq_mult at WIDTH=8.
// Compares against an integer-arithmetic product model; covers unsigned_mode when BOOTH_UNSIGNED_EN is defined.
module tb_booth_seq_mult;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        abort;
    logic [7:0]  multiplicand;
    logic [7:0]  multiplier;
    logic [15:0] product;
    logic        ready;
    logic        busy;
`ifdef BOOTH_UNSIGNED_EN
    logic        unsigned_mode;
`endif

    int checks = 0;
    int errors = 0;
    logic [15:0] model_product;

    booth_seq_mult #(.WIDTH(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .abort        (abort),
`ifdef BOOTH_UNSIGNED_EN
        .unsigned_mode(unsigned_mode),
`endif
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .product      (product),
        .ready        (ready),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    function automatic logic [15:0] refProduct(input logic [7:0] a, input logic [7:0] b, input logic uns);
        int sa, sb, p;
        sa = uns ? int'(a) : int'($signed(a));
        sb = uns ? int'(b) : int'($signed(b));
        p  = sa * sb;
        return p[15:0];
    endfunction

    // One operation: edge n counts posedges after the accept edge; abortAt>0 raises abort before edge abortAt.
    task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input logic uns,
                                 input int abortAt, input bit pokeStart, input string tag);
        int          iter, pulses, readyEdge, abortEdgeBusy;
        logic [15:0] expP, prodAtReady;
        logic        busyAtReady, busyAfterReady;
        iter           = uns ? 9 : 8;
        expP           = refProduct(a, b, uns);
        pulses         = 0;
        readyEdge      = -1;
        prodAtReady    = 'x;
        busyAtReady    = 1'bx;
        busyAfterReady = 1'bx;
        abortEdgeBusy  = -1;
        @(negedge clk);
        multiplicand = a;
        multiplier   = b;
`ifdef BOOTH_UNSIGNED_EN
        unsigned_mode = uns;
`endif
        start = 1'b1;
        @(posedge clk);
        #1;
        start        = 1'b0;
        multiplicand = 8'($urandom);
        multiplier   = 8'($urandom);
`ifdef BOOTH_UNSIGNED_EN
        unsigned_mode = 1'($urandom);
`endif
        checkOutput({tag, "_busy_after_accept"}, 32'(busy), 32'd1);
        for (int n = 1; n <= iter + 4; n++) begin
            start = pokeStart && (n <= iter + 2);
            abort = (n == abortAt);
            @(posedge clk);
            #1;
            if (n == abortAt) abortEdgeBusy = int'(busy);
            if (ready) begin
                pulses++;
                if (readyEdge < 0) begin
                    readyEdge   = n;
                    prodAtReady = product;
                    busyAtReady = busy;
                end
            end
            if (readyEdge > 0 && n == readyEdge + 1) busyAfterReady = busy;
        end
        start = 1'b0;
        abort = 1'b0;
        if (abortAt > 0) begin
            checkOutput({tag, "_abort_busy"}, 32'(abortEdgeBusy), 32'd0);
            checkOutput({tag, "_abort_no_ready"}, 32'(pulses), 32'd0);
            checkOutput({tag, "_abort_product_held"}, 32'(product), 32'(model_product));
        end else begin
            checkOutput({tag, "_ready_pulses"}, 32'(pulses), 32'd1);
            checkOutput({tag, "_latency"}, 32'(readyEdge), 32'(iter + 1));
            checkOutput({tag, "_product"}, 32'(prodAtReady), 32'(expP));
            checkOutput({tag, "_busy_in_ready"}, 32'(busyAtReady), 32'd1);
            checkOutput({tag, "_busy_after_ready"}, 32'(busyAfterReady), 32'd0);
            checkOutput({tag, "_product_hold"}, 32'(product), 32'(expP));
            model_product = expP;
        end
    endtask

    initial begin
        reset        = 1'b1;
        start        = 1'b0;
        abort        = 1'b0;
        multiplicand = '0;
        multiplier   = '0;
`ifdef BOOTH_UNSIGNED_EN
        unsigned_mode = 1'b0;
`endif
        model_product = '0;
        #1;
        checkOutput("reset_product", 32'(product), 32'd0);
        checkOutput("reset_ready", 32'(ready), 32'd0);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        #12;
        reset = 1'b0;

        applyStimulus(8'd3, 8'd5, 1'b0, 0, 1'b0, "3x5");
        applyStimulus(8'hF9, 8'd6, 1'b0, 0, 1'b0, "m7x6");
        applyStimulus(8'h80, 8'h80, 1'b0, 0, 1'b0, "m128xm128");
        applyStimulus(8'h80, 8'h7F, 1'b0, 0, 1'b0, "m128x127");
        applyStimulus(8'd25, 8'd4, 1'b0, 0, 1'b0, "25x4");
        applyStimulus(8'd77, 8'd91, 1'b0, 5, 1'b0, "abort_p4");
        applyStimulus(8'd13, 8'hF3, 1'b0, 0, 1'b0, "after_abort");
        applyStimulus(8'd1, 8'hFF, 1'b0, 2, 1'b0, "abort_first_step");
        applyStimulus(8'd100, 8'h9C, 1'b0, 1, 1'b0, "abort_setup");
        applyStimulus(8'd11, 8'd12, 1'b0, 0, 1'b1, "start_poke");

        // Asynchronous reset in the middle of PROCESS, away from any clock edge.
        @(negedge clk);
        multiplicand = 8'd57;
        multiplier   = 8'd33;
        start        = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        checkOutput("async_reset_product", 32'(product), 32'd0);
        checkOutput("async_reset_ready", 32'(ready), 32'd0);
        checkOutput("async_reset_busy", 32'(busy), 32'd0);
        #2;
        reset         = 1'b0;
        model_product = '0;
        applyStimulus(8'd9, 8'd9, 1'b0, 0, 1'b0, "9x9");

        for (int i = 0; i < 20; i++)
            applyStimulus(8'($urandom), 8'($urandom), 1'b0, 0, 1'b0, $sformatf("rand%0d", i));

`ifdef BOOTH_UNSIGNED_EN
        applyStimulus(8'hFF, 8'hFF, 1'b1, 0, 1'b0, "u255x255");
        applyStimulus(8'hFF, 8'hFF, 1'b0, 0, 1'b0, "s255x255");
        applyStimulus(8'hC8, 8'hE1, 1'b1, 6, 1'b0, "u_abort");
        for (int i = 0; i < 12; i++)
            applyStimulus(8'($urandom), 8'($urandom), 1'($urandom), 0, 1'b0, $sformatf("urand%0d", i));
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
